imm_extend_pipe: RTL and testbench

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_pkg.sv | 24 ++
 rtl/imm_format.sv | 47 ++++
 rtl/imm_extend_pipe.sv | 138 +++++++++++++
 tb/tb_imm_extend_pipe.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imm_pkg: immediate-format encodings and skid-buffer state encoding    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100,
    IMM_Z = 3'b101
  } imm_src_e;

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_TWO   = 2'd2
  } fifo_state_e;

endpackage
`default_nettype wire

// File: rtl/imm_format.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imm_format: RISC-V immediate assembly and extension to XLEN           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module imm_format
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [24:0]     instr,
  input  logic [2:0]      immsrc,
  output logic [XLEN-1:0] immext,
  output logic            illegal
);

  logic        sign;
  logic [31:0] imm32;

  // instr[k] holds instruction bit k+7, so instruction bit 31 is instr[24]
  assign sign = instr[24];

  always_comb begin
    imm32   = '0;
    illegal = 1'b0;
    case (imm_src_e'(immsrc))
      IMM_I:   imm32 = {{20{sign}}, instr[24:13]};
      IMM_S:   imm32 = {{20{sign}}, instr[24:18], instr[4:0]};
      IMM_B:   imm32 = {{20{sign}}, instr[0], instr[23:18], instr[4:1], 1'b0};
      IMM_J:   imm32 = {{12{sign}}, instr[12:5], instr[13], instr[23:14], 1'b0};
      IMM_U:   imm32 = {instr[24:5], 12'b0};
      IMM_Z:   imm32 = {27'b0, instr[12:8]};
      default: illegal = 1'b1;
    endcase
  end

  // Z and illegal leave bit 31 clear, so widening by bit 31 is correct for all
  generate
    if (XLEN > 32) begin : g_xlen_wide
      assign immext = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_xlen_32
      assign immext = imm32[XLEN-1:0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imm_extend_pipe: immediate extender with 2-entry output skid buffer   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      instr,
  input  logic [2:0]       immsrc,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  immext,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  logic [XLEN-1:0] fmt_imm;
  logic            fmt_illegal;

  imm_format #(
    .XLEN(XLEN)
  ) u_imm_format (
    .instr   (instr),
    .immsrc  (immsrc),
    .immext  (fmt_imm),
    .illegal (fmt_illegal)
  );

  fifo_state_e      state_q,     state_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q,  in_ready_d;
  logic [XLEN-1:0]  head_imm_q,  head_imm_d;
  logic [TAG_W-1:0] head_tag_q,  head_tag_d;
  logic             head_ill_q,  head_ill_d;
  logic [XLEN-1:0]  tail_imm_q,  tail_imm_d;
  logic [TAG_W-1:0] tail_tag_q,  tail_tag_d;
  logic             tail_ill_q,  tail_ill_d;

  logic push;
  logic pop;

  assign push = in_valid && in_ready_q && !flush;
  assign pop  = out_valid_q && out_ready && !flush;

  always_comb begin
    state_d    = state_q;
    head_imm_d = head_imm_q;
    head_tag_d = head_tag_q;
    head_ill_d = head_ill_q;
    tail_imm_d = tail_imm_q;
    tail_tag_d = tail_tag_q;
    tail_ill_d = tail_ill_q;

    case (state_q)
      FIFO_EMPTY: begin
        if (push) begin
          head_imm_d = fmt_imm;
          head_tag_d = in_tag;
          head_ill_d = fmt_illegal;
          state_d    = FIFO_ONE;
        end
      end
      FIFO_ONE: begin
        if (push && pop) begin
          head_imm_d = fmt_imm;
          head_tag_d = in_tag;
          head_ill_d = fmt_illegal;
        end else if (push) begin
          tail_imm_d = fmt_imm;
          tail_tag_d = in_tag;
          tail_ill_d = fmt_illegal;
          state_d    = FIFO_TWO;
        end else if (pop) begin
          state_d = FIFO_EMPTY;
        end
      end
      FIFO_TWO: begin
        // in_ready is low here, so the only event is draining the head
        if (pop) begin
          head_imm_d = tail_imm_q;
          head_tag_d = tail_tag_q;
          head_ill_d = tail_ill_q;
          state_d    = FIFO_ONE;
        end
      end
      default: state_d = FIFO_EMPTY;
    endcase

    if (flush) begin
      state_d = FIFO_EMPTY;
    end

    out_valid_d = (state_d != FIFO_EMPTY);
    in_ready_d  = (state_d != FIFO_TWO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FIFO_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      head_imm_q  <= '0;
      head_tag_q  <= '0;
      head_ill_q  <= 1'b0;
      tail_imm_q  <= '0;
      tail_tag_q  <= '0;
      tail_ill_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      head_imm_q  <= head_imm_d;
      head_tag_q  <= head_tag_d;
      head_ill_q  <= head_ill_d;
      tail_imm_q  <= tail_imm_d;
      tail_tag_q  <= tail_tag_d;
      tail_ill_q  <= tail_ill_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign immext      = head_imm_q;
  assign out_tag     = head_tag_q;
  assign out_illegal = head_ill_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// Scoreboard bench: two instances (XLEN 32 and 64) share stimulus; a reference
// model of the immediate formats feeds an expected-result queue.
module tb_imm_extend_pipe;

  localparam int TAG_W = 5;

  typedef struct {
    logic [63:0]      imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [24:0]      instr;
  logic [2:0]       immsrc;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_ready;

  logic             in_ready32, out_valid32, out_illegal32;
  logic [31:0]      immext32;
  logic [TAG_W-1:0] out_tag32;
  logic             in_ready64, out_valid64, out_illegal64;
  logic [63:0]      immext64;
  logic [TAG_W-1:0] out_tag64;

  imm_extend_pipe #(.XLEN(32), .TAG_W(TAG_W)) u_dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid32), .out_ready(out_ready), .immext(immext32),
    .out_tag(out_tag32), .out_illegal(out_illegal32)
  );

  imm_extend_pipe #(.XLEN(64), .TAG_W(TAG_W)) u_dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid64), .out_ready(out_ready), .immext(immext64),
    .out_tag(out_tag64), .out_illegal(out_illegal64)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   pop_count = 0;
  exp_t q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Immediate value from the ISA definition: unsigned field value, minus
  // 2^width when the sign bit is set.
  function automatic exp_t model(input logic [31:0] w, input logic [2:0] s, input logic [TAG_W-1:0] t);
    exp_t   e;
    longint v;
    e.ill = 1'b0;
    e.tag = t;
    case (s)
      3'd0: begin v = longint'(w[31:20]); if (w[31]) v -= 4096; end
      3'd1: begin v = longint'({w[31:25], w[11:7]}); if (w[31]) v -= 4096; end
      3'd2: begin v = longint'({w[31], w[7], w[30:25], w[11:8]}) * 2; if (w[31]) v -= 8192; end
      3'd3: begin v = longint'({w[31], w[19:12], w[20], w[30:21]}) * 2; if (w[31]) v -= 2097152; end
      3'd4: begin v = longint'(w[31:12]) * 4096; if (w[31]) v -= 64'sd4294967296; end
      3'd5: v = longint'(w[19:15]);
      default: begin v = 0; e.ill = 1'b1; end
    endcase
    e.imm = 64'(v);
    return e;
  endfunction

  // Monitor: compares handshake state against queue occupancy and pops results.
  logic             hold = 1'b0;
  logic [63:0]      prev_imm;
  logic [TAG_W-1:0] prev_tag;
  logic             prev_ill;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      chk("rst_out_valid", 64'(out_valid64), 64'd0);
      chk("rst_in_ready", 64'(in_ready64), 64'd1);
      chk("rst_immext", immext64, 64'd0);
      chk("rst_out_tag", 64'(out_tag64), 64'd0);
      chk("rst_out_illegal", 64'(out_illegal64), 64'd0);
      chk("rst_out_valid32", 64'(out_valid32), 64'd0);
      q.delete();
      hold = 1'b0;
    end else begin
      chk("out_valid", 64'(out_valid64), 64'(q.size() > 0));
      chk("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
      chk("in_ready", 64'(in_ready64), 64'(q.size() < 2));
      chk("in_ready32", 64'(in_ready32), 64'(q.size() < 2));
      if (hold) begin
        chk("stable_imm", immext64, prev_imm);
        chk("stable_tag", 64'(out_tag64), 64'(prev_tag));
        chk("stable_ill", 64'(out_illegal64), 64'(prev_ill));
      end
      if (flush) begin
        q.delete();
        hold = 1'b0;
      end else begin
        if (out_valid64 && out_ready && q.size() > 0) begin
          e = q.pop_front();
          chk("immext64", immext64, e.imm);
          chk("immext32", 64'(immext32), {32'd0, e.imm[31:0]});
          chk("out_tag64", 64'(out_tag64), 64'(e.tag));
          chk("out_tag32", 64'(out_tag32), 64'(e.tag));
          chk("out_illegal64", 64'(out_illegal64), 64'(e.ill));
          chk("out_illegal32", 64'(out_illegal32), 64'(e.ill));
          pop_count++;
        end
        hold     = out_valid64 && !out_ready;
        prev_imm = immext64;
        prev_tag = out_tag64;
        prev_ill = out_illegal64;
        if (in_valid && in_ready64)
          q.push_back(model({instr, 7'h00}, immsrc, in_tag));
      end
    end
  end

  // Holds a request until accepted; returns 1 ns after the accepting edge.
  task automatic send(input logic [31:0] w, input logic [2:0] s, input logic [TAG_W-1:0] t);
    int  n = 0;
    bit  done = 0;
    in_valid = 1'b1;
    instr    = w[31:7];
    immsrc   = s;
    in_tag   = t;
    while (!done) begin
      @(negedge clk);
      if (in_ready64 && !flush && !reset) done = 1;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 50) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: tag %0d not accepted after %0d cycles", t, n);
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int start;
    reset     = 1'b1;
    in_valid  = 1'b0;
    instr     = '0;
    immsrc    = '0;
    in_tag    = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reference decode vectors and illegal selectors
    out_ready = 1'b1;
    send(32'hFFF00093, 3'd0, 5'd1);
    send(32'hFE000EE3, 3'd2, 5'd2);
    send(32'h0080006F, 3'd3, 5'd3);
    send(32'h123450B7, 3'd4, 5'd4);
    send(32'h800000B7, 3'd4, 5'd5);
    send(32'h000F8073, 3'd5, 5'd6);
    send(32'h12345678, 3'd6, 5'd7);
    send(32'hFFFFFFFF, 3'd7, 5'd8);
    send(32'hFE1FF0A3, 3'd1, 5'd9);
    idle(3);

    // Backpressure: two fill the buffer, third is held off
    out_ready = 1'b0;
    send(32'h00100093, 3'd0, 5'd1);
    send(32'h00200093, 3'd0, 5'd2);
    #3 chk("bp_in_ready_low", 64'(in_ready64), 64'd0);
    in_valid = 1'b1;
    instr    = 25'h0001234;
    immsrc   = 3'd0;
    in_tag   = 5'd3;
    idle(3);
    #3 chk("bp_still_full", 64'(in_ready64), 64'd0);
    out_ready = 1'b1;
    send(32'h00300093, 3'd0, 5'd3);
    idle(4);

    // Streaming: one in, one out every cycle
    start = pop_count;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      instr    = 25'($urandom);
      immsrc   = 3'($urandom_range(0, 5));
      in_tag   = 5'(i + 10);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    idle(3);
    chk("stream_count", 64'(pop_count - start), 64'd10);

    // Flush while full, with a request presented in the same cycle
    out_ready = 1'b0;
    send(32'h00500093, 3'd0, 5'd20);
    send(32'h00600093, 3'd0, 5'd21);
    in_valid = 1'b1;
    instr    = 25'h1ABCDEF;
    in_tag   = 5'd22;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    #3;
    chk("flush_out_valid", 64'(out_valid64), 64'd0);
    chk("flush_in_ready", 64'(in_ready64), 64'd1);
    out_ready = 1'b1;
    idle(4);

    // Asynchronous reset mid-cycle while full
    out_ready = 1'b0;
    send(32'h00700093, 3'd0, 5'd23);
    send(32'h00800093, 3'd0, 5'd24);
    #2 reset = 1'b1;
    #1;
    chk("areset_out_valid", 64'(out_valid64), 64'd0);
    chk("areset_out_valid32", 64'(out_valid32), 64'd0);
    chk("areset_in_ready", 64'(in_ready64), 64'd1);
    chk("areset_immext", immext64, 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    send(32'hFFF00093, 3'd0, 5'd12);
    #3;
    chk("post_reset_latency", 64'(out_valid64), 64'd1);
    chk("post_reset_tag", 64'(out_tag64), 64'd12);
    idle(3);

    // Randomized traffic at several load/backpressure mixes
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 400; c++) begin
        in_valid  = ($urandom_range(0, 99) < (p == 0 ? 80 : (p == 1 ? 50 : 95)));
        out_ready = ($urandom_range(0, 99) < (p == 0 ? 80 : (p == 1 ? 95 : 30)));
        flush     = ($urandom_range(0, 99) < 2);
        instr     = 25'($urandom);
        immsrc    = 3'($urandom_range(0, 7));
        in_tag    = 5'($urandom);
        @(posedge clk);
        #1;
      end
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    idle(5);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
